// File: rtl/cpu_controller.sv
// Multi-cycle instruction controller: accepts one 16-bit instruction, decodes it, strobes write enables in WRITEBACK.
// Latency: accept at edge N, strobes during the third cycle after it, ready again in the fourth; instrValid ignored while busy.
module cpu_controller #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     instrValid,
    output logic                     instrReady,
    input  logic [15:0]              instruction,
    output logic [REG_ADDR_BITS-1:0] regAddressA,
    output logic [REG_ADDR_BITS-1:0] regAddressB,
    output logic [3:0]               aluOpCode,
    output logic                     immSelect,
    output logic [REG_WIDTH-1:0]     immediate,
    output logic                     regWriteEnable,
    output logic                     flagWriteEnable,
    output logic                     illegalInstr,
    output logic [15:0]              instrCount
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] instr_q;
    logic [3:0]  op;
    logic [3:0]  code;
    logic        legal;
    logic        writes_reg;
    logic        writes_flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            instr_q    <= '0;
            instrCount <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && instrValid) begin
                instr_q <= instruction;
            end
            if (state == WRITEBACK && legal) begin
                instrCount <= instrCount + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (instrValid) state_nxt = DECODE;
            DECODE:    state_nxt = EXECUTE;
            EXECUTE:   state_nxt = WRITEBACK;
            WRITEBACK: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // op==0 selects the register form, whose ALU code lives in the opExt field
    always_comb begin
        op          = instr_q[15:12];
        code        = (op == 4'd0) ? instr_q[7:4] : op;
        legal       = 1'b0;
        writes_reg  = 1'b0;
        writes_flag = 1'b0;
        case (code)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd6: begin
                legal      = 1'b1;
                writes_reg = 1'b1;
            end
            4'd5, 4'd7, 4'd9, 4'd10: begin
                legal       = 1'b1;
                writes_reg  = 1'b1;
                writes_flag = 1'b1;
            end
            4'd11: begin
                legal       = 1'b1;
                writes_flag = 1'b1;
            end
            default: ;
        endcase
    end

    // Decoded fields come straight from the latched instruction, so they hold through IDLE
    always_comb begin
        instrReady      = (state == IDLE);
        regAddressA     = REG_ADDR_BITS'(instr_q[11:8]);
        regAddressB     = REG_ADDR_BITS'(instr_q[3:0]);
        aluOpCode       = code;
        immSelect       = (op != 4'd0);
        immediate       = {{(REG_WIDTH-8){instr_q[7]}}, instr_q[7:0]};
        regWriteEnable  = 1'b0;
        flagWriteEnable = 1'b0;
        illegalInstr    = 1'b0;
        if (state == WRITEBACK) begin
            regWriteEnable  = writes_reg;
            flagWriteEnable = writes_flag;
            illegalInstr    = !legal;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed vector table, reset/backpressure sequences, random traffic vs a phase model.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instrValid = 1'b0;
    logic [15:0] instruction = '0;
    logic        instrReady;
    logic [3:0]  regAddressA, regAddressB, aluOpCode;
    logic        immSelect, regWriteEnable, flagWriteEnable, illegalInstr;
    logic [15:0] immediate, instrCount;

    cpu_controller #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
        .clk(clk), .reset(reset), .instrValid(instrValid), .instrReady(instrReady),
        .instruction(instruction), .regAddressA(regAddressA), .regAddressB(regAddressB),
        .aluOpCode(aluOpCode), .immSelect(immSelect), .immediate(immediate),
        .regWriteEnable(regWriteEnable), .flagWriteEnable(flagWriteEnable),
        .illegalInstr(illegalInstr), .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: cycles elapsed since the accept (0 = waiting), the held instruction, retired count.
    int          m_phase = 0;
    logic [15:0] m_cur = '0;
    logic [15:0] m_cnt = '0;
    logic [15:0] legal_mask, wr_mask, flag_mask;
    int legal_list[10] = '{1, 2, 3, 4, 5, 6, 7, 9, 10, 11};
    int flag_list[5]   = '{5, 7, 9, 10, 11};

    function automatic logic [3:0] m_code(input logic [15:0] ins);
        return (ins[15:12] == 4'd0) ? ins[7:4] : ins[15:12];
    endfunction

    task automatic model_edge();
        if (!reset) begin
            m_phase = 0; m_cur = '0; m_cnt = '0;
        end else if (m_phase == 3) begin
            if (legal_mask[m_code(m_cur)]) m_cnt = m_cnt + 16'd1;
            m_phase = 0;
        end else if (m_phase > 0) begin
            m_phase = m_phase + 1;
        end else if (instrValid) begin
            m_cur = instruction;
            m_phase = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [3:0] c;
        logic       wb;
        c  = m_code(m_cur);
        wb = (m_phase == 3);
        check({tag, ".ready"}, instrReady, m_phase == 0);
        check({tag, ".regA"}, regAddressA, m_cur[11:8]);
        check({tag, ".regB"}, regAddressB, m_cur[3:0]);
        check({tag, ".aluOp"}, aluOpCode, c);
        check({tag, ".immSel"}, immSelect, m_cur[15:12] != 4'd0);
        check({tag, ".imm"}, immediate, {{8{m_cur[7]}}, m_cur[7:0]});
        check({tag, ".regWr"}, regWriteEnable, wb && wr_mask[c]);
        check({tag, ".flagWr"}, flagWriteEnable, wb && flag_mask[c]);
        check({tag, ".illegal"}, illegalInstr, wb && !legal_mask[c]);
        check({tag, ".count"}, instrCount, m_cnt);
    endtask

    typedef struct {
        logic [15:0] instr;
        logic [3:0]  a, b, op;
        logic        sel;
        logic [15:0] imm;
        logic        wr, flag, ill;
    } vec_t;

    vec_t vecs[8];
    logic [15:0] exp_cnt;
    int accepts;

    initial begin
        legal_mask = '0; flag_mask = '0;
        foreach (legal_list[i]) legal_mask[legal_list[i]] = 1'b1;
        foreach (flag_list[i]) flag_mask[flag_list[i]] = 1'b1;
        wr_mask = legal_mask;
        wr_mask[11] = 1'b0;

        //            instr     A     B     op    sel   imm        wr    flag  ill
        vecs[0] = '{16'h0251, 4'h2, 4'h1, 4'h5, 1'b0, 16'h0051, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h03B4, 4'h3, 4'h4, 4'hB, 1'b0, 16'hFFB4, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h53FF, 4'h3, 4'hF, 4'h5, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h02F1, 4'h2, 4'h1, 4'hF, 1'b0, 16'hFFF1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'h1A7C, 4'hA, 4'hC, 4'h1, 1'b1, 16'h007C, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8123, 4'h1, 4'h3, 4'h8, 1'b1, 16'h0023, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'hB580, 4'h5, 4'h0, 4'hB, 1'b1, 16'hFF80, 1'b0, 1'b1, 1'b0};

        // Reset state
        tick();
        tick();
        check("rst.ready", instrReady, 1'b1);
        check("rst.outs", {regAddressA, regAddressB, aluOpCode, immSelect, regWriteEnable,
                           flagWriteEnable, illegalInstr}, '0);
        check("rst.imm", immediate, 16'h0);
        check("rst.count", instrCount, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        exp_cnt = 16'h0;
        foreach (vecs[i]) begin
            instruction = vecs[i].instr;
            instrValid = 1'b1;
            check("vec.ready_at_offer", instrReady, 1'b1);
            tick();
            instrValid = 1'b0;
            instruction = $urandom;
            for (int cyc = 1; cyc <= 3; cyc++) begin
                check("vec.ready_busy", instrReady, 1'b0);
                check("vec.regA", regAddressA, vecs[i].a);
                check("vec.regB", regAddressB, vecs[i].b);
                check("vec.aluOp", aluOpCode, vecs[i].op);
                check("vec.immSel", immSelect, vecs[i].sel);
                check("vec.imm", immediate, vecs[i].imm);
                check("vec.regWr", regWriteEnable, (cyc == 3) && vecs[i].wr);
                check("vec.flagWr", flagWriteEnable, (cyc == 3) && vecs[i].flag);
                check("vec.illegal", illegalInstr, (cyc == 3) && vecs[i].ill);
                check("vec.count_busy", instrCount, exp_cnt);
                tick();
            end
            if (!vecs[i].ill) exp_cnt = exp_cnt + 16'd1;
            check("vec.ready_after", instrReady, 1'b1);
            check("vec.count", instrCount, exp_cnt);
            check("vec.strobes_idle", {regWriteEnable, flagWriteEnable, illegalInstr}, 3'b000);
            check("vec.regA_held", regAddressA, vecs[i].a);
            check("vec.aluOp_held", aluOpCode, vecs[i].op);
        end

        // Reset asserted mid-EXECUTE: aborts immediately with no strobe
        instruction = 16'h0251;
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        tick();
        #2;
        reset = 1'b0;
        model_edge();
        #1;
        check("abort.ready", instrReady, 1'b1);
        check("abort.outs", {regAddressA, regAddressB, aluOpCode, immSelect, regWriteEnable,
                             flagWriteEnable, illegalInstr}, '0);
        check("abort.imm", immediate, 16'h0);
        check("abort.count", instrCount, 16'h0);
        instrValid = 1'b1;
        instruction = 16'h53FF;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("inreset.regA", regAddressA, 4'h0);
            check("inreset.count", instrCount, 16'h0);
        end
        @(negedge clk);
        instrValid = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_model("post_abort");
        end

        // instrValid held for 12 edges: one accept every 4 cycles
        accepts = 0;
        instruction = 16'h0251;
        instrValid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (instrReady) accepts++;
            tick();
        end
        instrValid = 1'b0;
        check("hold.accepts", accepts, 3);
        check("hold.count", instrCount, 16'd3);
        check_model("hold");

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            instrValid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0)
                instruction = 16'($urandom);
            else
                instruction = {4'h0, 4'($urandom), 4'(legal_list[$urandom_range(0, 9)]), 4'($urandom)};
            tick();
            check_model("rand");
        end
        instrValid = 1'b0;

        // Counter wrap: preload near the top, then retire two legal instructions
        for (int k = 0; k < 8 && m_phase != 0; k++) tick();
        check("wrap.idle", instrReady, 1'b1);
        @(negedge clk);
        force dut.instrCount = 16'hFFFE;
        #1;
        release dut.instrCount;
        m_cnt = 16'hFFFE;
        for (int j = 0; j < 2; j++) begin
            instruction = 16'h5301;
            instrValid = 1'b1;
            tick();
            instrValid = 1'b0;
            for (int c = 0; c < 3; c++) tick();
            check_model("wrap");
        end
        check("wrap.count", instrCount, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter: REG_WIDTH, 16, datapath/immediate width.
REQ-002 SHALL have parameter: REG_ADDR_BITS, 4, register address width.
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: instrValid  input  1  instruction offered.
REQ-006 SHALL have port: instrReady  output  1  controller can accept.
REQ-007 SHALL have port: instruction  input  16  [15:12] op, [11:8] Rdest, [7:4] opExt, [3:0] Rsrc; immediate = [7:0].
REQ-008 SHALL have port: regAddressA  output  REG_ADDR_BITS  Rdest read/write address.
REQ-009 SHALL have port: regAddressB  output  REG_ADDR_BITS  Rsrc read address.
REQ-010 SHALL have port: aluOpCode  output  4  ALU operation.
REQ-011 SHALL have port: immSelect  output  1  ALU B-operand from immediate.
REQ-012 SHALL have port: immediate  output  REG_WIDTH  sign-extended instruction[7:0].
REQ-013 SHALL have port: regWriteEnable  output  1  register-file write strobe.
REQ-014 SHALL have port: flagWriteEnable  output  1  flag register write strobe.
REQ-015 SHALL have port: illegalInstr  output  1  one-cycle undecodable-instruction pulse.
REQ-016 SHALL have port: instrCount  output  16  retired-instruction counter.

Function
REQ-017 SHALL implement FSM IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE; DECODE, EXECUTE, WRITEBACK each last exactly one cycle.
REQ-018 SHALL drive instrReady=1 only in IDLE; accept on rising edge with instrValid&instrReady, latching instruction and moving to DECODE.
REQ-019 SHALL ignore instrValid outside IDLE; at most one accept per 4 cycles.
REQ-020 SHALL decode R-type when op=0000: aluOpCode=opExt, immSelect=0.
REQ-021 SHALL decode I-type when op!=0000: aluOpCode=op, immSelect=1, immediate={8{instr[7]}, instr[7:0]} for REG_WIDTH=16.
REQ-022 SHALL treat legal codes as 0001 AND, 0010 OR, 0011 XOR, 0100 LSH, 0101 ADD, 0110 ADDU, 0111 ADDC, 1001 SUB, 1010 SUBC, 1011 CMP; all others illegal.
REQ-023 SHALL present regAddressA/B, aluOpCode, immSelect, immediate from DECODE through WRITEBACK, holding last values in IDLE.
REQ-024 SHALL pulse regWriteEnable for one cycle in WRITEBACK for every legal code except CMP.
REQ-025 SHALL pulse flagWriteEnable for one cycle in WRITEBACK for ADD, ADDC, SUB, SUBC, CMP only.
REQ-026 SHALL, for illegal codes, pulse illegalInstr in WRITEBACK with regWriteEnable=flagWriteEnable=0 and instrCount unchanged.
REQ-027 SHALL increment instrCount on leaving WRITEBACK for legal instructions, wrapping FFFF -> 0000.
REQ-028 SHALL yield latency: accept at edge N -> strobes high during cycle N+3 -> instrReady high in cycle N+4.

Reset
REQ-029 SHALL, while reset=0, immediately force IDLE, instrReady=1, all other outputs 0, instrCount=0.
REQ-030 SHALL abort any in-flight instruction on reset with no write or illegal pulse, and never accept while reset=0.

Verification
REQ-031 SHALL cover 0x0251 (ADD R2,R1) -> cycles 1-3 regAddressA=2, regAddressB=1, aluOpCode=0101, immSelect=0; regWriteEnable=flagWriteEnable=1 only in cycle 3; instrCount=1.
REQ-032 SHALL cover 0x03B4 (CMP R3,R4) -> flagWriteEnable=1, regWriteEnable=0 in WRITEBACK; instrCount increments.
REQ-033 SHALL cover 0x53FF (ADDI R3,-1) -> immSelect=1, immediate=0xFFFF, aluOpCode=0101; both strobes pulse.
REQ-034 SHALL cover 0x02F1 (opExt 1111) -> illegalInstr one-cycle pulse, no strobes, instrCount unchanged.
REQ-035 SHALL cover reset=0 during EXECUTE -> outputs 0 same cycle, no strobe; after release instrReady=1, instrCount=0.
REQ-036 SHALL cover instrValid held high for 12 cycles -> exactly 3 accepts, instrCount=3, instrCount wraps after preload-by-execution test to 0xFFFF+1=0.
